// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the forwarding / hazard controller.
//   - FWD_* constants: the operand mux encoding (00 regfile, 01 WB, 10 EX)
//   - fsm_state_e:     controller state, exported for observability
//   - slot_t:          one scoreboard entry (EX or WB stage)
package hazard_pkg;

  // Register index width carried in a scoreboard slot; the top-level
  // REG_ADDR_W parameter must equal this value.
  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_EX = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10
  } fsm_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             is_load;
  } slot_t;

endpackage

// File: rtl/fwd_match.sv
// fwd_match: forwarding select for one source operand.
//   src_i      source register index from decode
//   use_i      source is actually read
//   ex_i/wb_i  scoreboard slots for the EX and WB stages
//   sel_o      2-bit operand mux select (FWD_RF / FWD_WB / FWD_EX)
//   load_use_o EX holds a load producing this source
module fwd_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  input  slot_t            ex_i,
  input  slot_t            wb_i,
  output logic [1:0]       sel_o,
  output logic             load_use_o
);

  logic ex_hit;
  logic wb_hit;

  // x0 is hardwired to zero, so a producer of x0 never matches.
  assign ex_hit = use_i && ex_i.valid && ex_i.reg_write &&
                  (ex_i.rd != '0) && (ex_i.rd == src_i);
  assign wb_hit = use_i && wb_i.valid && wb_i.reg_write &&
                  (wb_i.rd != '0) && (wb_i.rd == src_i);

  // A load in EX has no result yet, so it cannot feed the EX path; the
  // select falls through to WB and the load-use flag requests a stall.
  always_comb begin
    sel_o = FWD_RF;
    if (ex_hit && !ex_i.is_load) begin
      sel_o = FWD_EX;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

  assign load_use_o = ex_hit && ex_i.is_load;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding and hazard control for a 3-stage RV32I pipe.
//   Inputs : decode-slot info (id_*), branch_taken from EX, mem_ready for
//            load data in WB.
//   Outputs: fwd_a_sel/fwd_b_sel operand mux selects, stall/bubble/freeze/
//            flush pipeline controls (combinational), mem_timeout sticky
//            error, stall_cycles performance counter, fsm_state for
//            observability.
// Handshake: none; every output is meaningful every cycle. Control outputs
// are a same-cycle function of inputs and registered scoreboard state.
module fwd_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  branch_taken,
  input  logic                  mem_ready,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  bubble,
  output logic                  freeze,
  output logic                  flush,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [1:0]            fsm_state
);

  localparam int               WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  slot_t            ex_q, ex_d;
  slot_t            wb_q, wb_d;
  fsm_state_e       state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_inc;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic lu_a;
  logic lu_b;
  logic load_use;

  fwd_match u_fwd_a (
    .src_i      (id_rs1),
    .use_i      (id_uses_rs1),
    .ex_i       (ex_q),
    .wb_i       (wb_q),
    .sel_o      (fwd_a_sel),
    .load_use_o (lu_a)
  );

  fwd_match u_fwd_b (
    .src_i      (id_rs2),
    .use_i      (id_uses_rs2),
    .ex_i       (ex_q),
    .wb_i       (wb_q),
    .sel_o      (fwd_b_sel),
    .load_use_o (lu_b)
  );

  assign load_use = lu_a || lu_b;

  // Freeze dominates everything; flush dominates load-use. A load-use seen
  // under freeze is simply re-evaluated once the freeze lifts.
  assign freeze = wb_q.valid && wb_q.is_load && !mem_ready;
  assign flush  = branch_taken && !freeze;
  assign bubble = load_use && !freeze && !flush;
  assign stall  = freeze || bubble;

  // Scoreboard advance: everything holds under freeze; otherwise EX moves
  // to WB and decode enters EX unless it is being bubbled or squashed.
  always_comb begin
    ex_d = ex_q;
    wb_d = wb_q;
    if (!freeze) begin
      wb_d = ex_q;
      if (bubble || flush || !id_valid) begin
        ex_d = '0;
      end else begin
        ex_d.valid     = 1'b1;
        ex_d.rd        = id_rd;
        ex_d.reg_write = id_reg_write;
        ex_d.is_load   = id_is_load;
      end
    end
  end

  // Wait counter saturates at the limit so it cannot wrap back under it.
  assign wait_inc = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      wb_q        <= '0;
      state_q     <= ST_RUN;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      wb_q <= wb_d;

      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end

      case (state_q)
        ST_RUN: begin
          if (freeze) begin
            state_q <= ST_MEM_WAIT;
            wait_q  <= '0;
          end else if (load_use && !flush) begin
            state_q <= ST_LU_STALL;
          end
        end
        ST_LU_STALL: begin
          if (freeze) begin
            state_q <= ST_MEM_WAIT;
            wait_q  <= '0;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          wait_q <= wait_inc;
          if (wait_inc == WAIT_LIMIT) begin
            timeout_q <= 1'b1;
          end
          if (mem_ready) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign fsm_state    = state_q;

endmodule
